// File: rtl/mouse_board_cursor_if.sv
// Mouse report input bus and cursor / board-selection result bus.
interface mouse_board_cursor_if #(
  parameter int unsigned POS_W     = 10,
  parameter int unsigned DISP_W    = 8,
  parameter int unsigned N_BUTTONS = 3
);
  logic                 report_valid;
  logic [DISP_W-1:0]    x_disp;
  logic [DISP_W-1:0]    y_disp;
  logic [N_BUTTONS-1:0] button_status;

  logic [POS_W-1:0]     cursor_x;
  logic [POS_W-1:0]     cursor_y;
  logic [2:0]           sq_col;
  logic [2:0]           sq_row;
  logic                 sq_valid;
  logic [N_BUTTONS-1:0] btn_press;
  logic [N_BUTTONS-1:0] btn_release;
  logic                 selected;
  logic [2:0]           from_col;
  logic [2:0]           from_row;
  logic                 move_valid;
  logic [2:0]           to_col;
  logic [2:0]           to_row;

  // Report source (PIO side / testbench)
  modport master (
    output report_valid, x_disp, y_disp, button_status,
    input  cursor_x, cursor_y, sq_col, sq_row, sq_valid, btn_press, btn_release,
    input  selected, from_col, from_row, move_valid, to_col, to_row
  );

  // Cursor / board block
  modport slave (
    input  report_valid, x_disp, y_disp, button_status,
    output cursor_x, cursor_y, sq_col, sq_row, sq_valid, btn_press, btn_release,
    output selected, from_col, from_row, move_valid, to_col, to_row
  );
endinterface

// File: rtl/mouse_board_cursor.sv
// Mouse reports -> clamped cursor -> board square -> click-to-move selection FSM.
// Stage 1 updates cursor and button edges; stage 2 maps the square and runs the FSM.
module mouse_board_cursor #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned DISP_W    = 8,
  parameter int unsigned N_BUTTONS = 3,
  parameter int unsigned BOARD_X0  = 80,
  parameter int unsigned BOARD_Y0  = 0,
  parameter int unsigned SQUARE    = 60,
  parameter int unsigned BOARD_N   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mouse_board_cursor_if.slave mb
);

  localparam int unsigned SW = POS_W + 2;

  localparam int BX0  = int'(BOARD_X0);
  localparam int BY0  = int'(BOARD_Y0);
  localparam int SQ   = int'(SQUARE);
  localparam int BN   = int'(BOARD_N);
  localparam int SPAN = BN * SQ;
  localparam int CX   = int'(SCREEN_W / 2);
  localparam int CY   = int'(SCREEN_H / 2);

  localparam bit RST_ON  = (CX >= BX0) && (CX < BX0 + SPAN) && (CY >= BY0) && (CY < BY0 + SPAN);
  localparam int RST_COL = RST_ON ? (CX - BX0) / SQ : 0;
  localparam int RST_ROW = RST_ON ? (CY - BY0) / SQ : 0;

  localparam logic signed [SW-1:0] XMAX_S = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0] YMAX_S = SW'(SCREEN_H - 1);
  localparam logic [POS_W-1:0]     XMAX   = POS_W'(SCREEN_W - 1);
  localparam logic [POS_W-1:0]     YMAX   = POS_W'(SCREEN_H - 1);

  typedef enum logic [0:0] {S_IDLE, S_ARMED} state_t;

  // Stage 1 state
  logic [POS_W-1:0]     r_cursor_x, r_cursor_y;
  logic [N_BUTTONS-1:0] r_prev_btn, r_press, r_release;

  // Stage 2 state
  logic [2:0]           r_sq_col, r_sq_row;
  logic                 r_sq_valid;
  state_t               r_state, w_state_nxt;
  logic                 r_selected, w_selected_nxt;
  logic [2:0]           r_from_col, r_from_row, w_from_col_nxt, w_from_row_nxt;
  logic [2:0]           r_to_col, r_to_row, w_to_col_nxt, w_to_row_nxt;
  logic                 r_move_valid, w_move_valid_nxt;

  logic signed [SW-1:0] w_sum_x, w_sum_y;
  logic [POS_W-1:0]     w_nx, w_ny;
  int                   w_offx, w_offy;
  logic                 w_on;
  logic [2:0]           w_col, w_row;
  logic                 w_left, w_right;

  assign w_sum_x = $signed({2'b00, r_cursor_x}) + SW'($signed(mb.x_disp));
  assign w_sum_y = $signed({2'b00, r_cursor_y}) + SW'($signed(mb.y_disp));

  // Clamp the displaced position to the visible screen
  always_comb begin
    w_nx = w_sum_x[POS_W-1:0];
    w_ny = w_sum_y[POS_W-1:0];
    if (w_sum_x[SW-1])          w_nx = '0;
    else if (w_sum_x > XMAX_S)  w_nx = XMAX;
    if (w_sum_y[SW-1])          w_ny = '0;
    else if (w_sum_y > YMAX_S)  w_ny = YMAX;
  end

  // Stage 1: cursor update and button edge detection on each report
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cursor_x <= POS_W'(CX);
      r_cursor_y <= POS_W'(CY);
      r_prev_btn <= '0;
      r_press    <= '0;
      r_release  <= '0;
    end else if (mb.report_valid) begin
      r_cursor_x <= w_nx;
      r_cursor_y <= w_ny;
      r_press    <= mb.button_status & ~r_prev_btn;
      r_release  <= ~mb.button_status & r_prev_btn;
      r_prev_btn <= mb.button_status;
    end else begin
      r_press    <= '0;
      r_release  <= '0;
    end
  end

  // Board hit test and square index via constant threshold chain
  always_comb begin
    w_offx = int'(r_cursor_x) - BX0;
    w_offy = int'(r_cursor_y) - BY0;
    w_on   = (w_offx >= 0) && (w_offx < SPAN) && (w_offy >= 0) && (w_offy < SPAN);
    w_col  = '0;
    w_row  = '0;
    for (int k = 1; k < BN; k++) begin
      if (w_offx >= k * SQ) w_col = 3'(k);
      if (w_offy >= k * SQ) w_row = 3'(k);
    end
  end

  assign w_left = r_press[0];

  // Cancel button exists only with two or more buttons
  if (N_BUTTONS > 1) begin : g_right
    assign w_right = r_press[1];
  end else begin : g_no_right
    assign w_right = 1'b0;
  end

  // Selection FSM next state and outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_selected_nxt   = r_selected;
    w_from_col_nxt   = r_from_col;
    w_from_row_nxt   = r_from_row;
    w_to_col_nxt     = r_to_col;
    w_to_row_nxt     = r_to_row;
    w_move_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_left && w_on) begin
          w_state_nxt    = S_ARMED;
          w_selected_nxt = 1'b1;
          w_from_col_nxt = w_col;
          w_from_row_nxt = w_row;
        end
      end
      S_ARMED: begin
        if (w_right) begin
          w_state_nxt    = S_IDLE;
          w_selected_nxt = 1'b0;
        end else if (w_left) begin
          w_state_nxt    = S_IDLE;
          w_selected_nxt = 1'b0;
          // Clicking the held square or off-board just deselects
          if (w_on && ((w_col != r_from_col) || (w_row != r_from_row))) begin
            w_move_valid_nxt = 1'b1;
            w_to_col_nxt     = w_col;
            w_to_row_nxt     = w_row;
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_selected_nxt = 1'b0;
      end
    endcase
  end

  // Stage 2 registers: square outputs and FSM state/outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sq_col     <= 3'(RST_COL);
      r_sq_row     <= 3'(RST_ROW);
      r_sq_valid   <= RST_ON;
      r_state      <= S_IDLE;
      r_selected   <= 1'b0;
      r_from_col   <= '0;
      r_from_row   <= '0;
      r_to_col     <= '0;
      r_to_row     <= '0;
      r_move_valid <= 1'b0;
    end else begin
      if (w_on) begin
        r_sq_col <= w_col;
        r_sq_row <= w_row;
      end
      r_sq_valid   <= w_on;
      r_state      <= w_state_nxt;
      r_selected   <= w_selected_nxt;
      r_from_col   <= w_from_col_nxt;
      r_from_row   <= w_from_row_nxt;
      r_to_col     <= w_to_col_nxt;
      r_to_row     <= w_to_row_nxt;
      r_move_valid <= w_move_valid_nxt;
    end
  end

  assign mb.cursor_x    = r_cursor_x;
  assign mb.cursor_y    = r_cursor_y;
  assign mb.sq_col      = r_sq_col;
  assign mb.sq_row      = r_sq_row;
  assign mb.sq_valid    = r_sq_valid;
  assign mb.btn_press   = r_press;
  assign mb.btn_release = r_release;
  assign mb.selected    = r_selected;
  assign mb.from_col    = r_from_col;
  assign mb.from_row    = r_from_row;
  assign mb.move_valid  = r_move_valid;
  assign mb.to_col      = r_to_col;
  assign mb.to_row      = r_to_row;

endmodule

// File: tb/tb_mouse_board_cursor.sv
// Directed bench for mouse_board_cursor with hand-computed expectations.
module tb_mouse_board_cursor;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   n_moves;
  logic [9:0] s1_cx, s1_cy;
  logic [2:0] s1_press, s1_rel;

  mouse_board_cursor_if #(.POS_W(10), .DISP_W(8), .N_BUTTONS(3)) mb ();

  mouse_board_cursor dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mb      (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles on which a move was issued
  always @(posedge clk) if (reset_n && mb.move_valid === 1'b1) n_moves++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One report: stage-1 outputs captured into s1_*, returns with stage-2 outputs visible
  task automatic report(input logic [7:0] dx, input logic [7:0] dy, input logic [2:0] btn);
    @(negedge clk);
    mb.report_valid  = 1'b1;
    mb.x_disp        = dx;
    mb.y_disp        = dy;
    mb.button_status = btn;
    @(negedge clk);
    mb.report_valid  = 1'b0;
    mb.x_disp        = '0;
    mb.y_disp        = '0;
    s1_cx    = mb.cursor_x;
    s1_cy    = mb.cursor_y;
    s1_press = mb.btn_press;
    s1_rel   = mb.btn_release;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_moves = 0;
    mb.report_valid = 1'b0; mb.x_disp = '0; mb.y_disp = '0; mb.button_status = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_cx", 32'(mb.cursor_x), 320);
    check_eq("rst_cy", 32'(mb.cursor_y), 240);
    check_eq("rst_col", 32'(mb.sq_col), 4);
    check_eq("rst_row", 32'(mb.sq_row), 4);
    check_eq("rst_sqv", 32'(mb.sq_valid), 1);
    check_eq("rst_sel", 32'(mb.selected), 0);
    check_eq("rst_mv", 32'(mb.move_valid), 0);
    check_eq("rst_press", 32'(mb.btn_press), 0);
    reset_n = 1'b1;

    // Basic displacement
    report(8'h10, 8'hF0, 3'b000);
    check_eq("mv_cx", 32'(s1_cx), 336);
    check_eq("mv_cy", 32'(s1_cy), 224);
    check_eq("mv_col", 32'(mb.sq_col), 4);
    check_eq("mv_row", 32'(mb.sq_row), 3);
    check_eq("mv_sqv", 32'(mb.sq_valid), 1);

    // Clamp right edge: 463, 590, 639, 639, 639
    for (int i = 0; i < 5; i++) report(8'h7F, 8'h00, 3'b000);
    check_eq("clamp_hi_cx", 32'(mb.cursor_x), 639);
    check_eq("clamp_hi_sqv", 32'(mb.sq_valid), 0);
    check_eq("hold_col", 32'(mb.sq_col), 6);
    // Clamp left edge: 511, 383, 255, 127, 0, 0
    for (int i = 0; i < 6; i++) report(8'h80, 8'h00, 3'b000);
    check_eq("clamp_lo_cx", 32'(mb.cursor_x), 0);
    check_eq("clamp_lo_cy", 32'(mb.cursor_y), 224);

    // Move to (100,10), select, move to (100,70), click -> move (0,0)->(0,1)
    report(8'h64, 8'h80, 3'b000);
    report(8'h00, 8'hAA, 3'b000);
    check_eq("pos_a_cx", 32'(mb.cursor_x), 100);
    check_eq("pos_a_cy", 32'(mb.cursor_y), 10);
    report(8'h00, 8'h00, 3'b001);
    check_eq("sel_press", 32'(s1_press), 1);
    check_eq("sel_sel", 32'(mb.selected), 1);
    check_eq("sel_fcol", 32'(mb.from_col), 0);
    check_eq("sel_frow", 32'(mb.from_row), 0);
    report(8'h00, 8'h3C, 3'b000);
    check_eq("rel_pulse", 32'(s1_rel), 1);
    check_eq("rel_sel", 32'(mb.selected), 1);
    check_eq("pos_b_row", 32'(mb.sq_row), 1);
    report(8'h00, 8'h00, 3'b001);
    check_eq("move_mv", 32'(mb.move_valid), 1);
    check_eq("move_tcol", 32'(mb.to_col), 0);
    check_eq("move_trow", 32'(mb.to_row), 1);
    check_eq("move_fcol", 32'(mb.from_col), 0);
    check_eq("move_frow", 32'(mb.from_row), 0);
    check_eq("move_sel", 32'(mb.selected), 0);
    @(negedge clk);
    check_eq("move_pulse_end", 32'(mb.move_valid), 0);

    // Go to (320,240) = square (4,4), arm, then left+right together cancels
    report(8'h7F, 8'h7F, 3'b000);
    report(8'h5D, 8'h2B, 3'b000);
    check_eq("pos_c_cx", 32'(mb.cursor_x), 320);
    check_eq("pos_c_cy", 32'(mb.cursor_y), 240);
    report(8'h00, 8'h00, 3'b001);
    check_eq("arm44_sel", 32'(mb.selected), 1);
    check_eq("arm44_fcol", 32'(mb.from_col), 4);
    check_eq("arm44_frow", 32'(mb.from_row), 4);
    report(8'h00, 8'h00, 3'b000);
    report(8'h00, 8'h00, 3'b011);
    check_eq("cancel_press", 32'(s1_press), 3);
    check_eq("cancel_sel", 32'(mb.selected), 0);
    check_eq("cancel_mv", 32'(mb.move_valid), 0);

    // Re-arm, hold button, then click the same square to deselect
    report(8'h00, 8'h00, 3'b000);
    report(8'h00, 8'h00, 3'b001);
    check_eq("rearm_sel", 32'(mb.selected), 1);
    report(8'h00, 8'h00, 3'b001);
    check_eq("held_press", 32'(s1_press), 0);
    check_eq("held_sel", 32'(mb.selected), 1);
    report(8'h00, 8'h00, 3'b000);
    report(8'h00, 8'h00, 3'b001);
    check_eq("same_sel", 32'(mb.selected), 0);
    check_eq("same_mv", 32'(mb.move_valid), 0);

    // Arm elsewhere, then reset mid-selection
    report(8'h10, 8'h00, 3'b000);
    check_eq("pos_d_cx", 32'(mb.cursor_x), 336);
    report(8'h00, 8'h00, 3'b001);
    check_eq("arm_d_sel", 32'(mb.selected), 1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_sel", 32'(mb.selected), 0);
    check_eq("arst_cx", 32'(mb.cursor_x), 320);
    check_eq("arst_fcol", 32'(mb.from_col), 0);
    check_eq("arst_mv", 32'(mb.move_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back reports, one per cycle
    @(negedge clk);
    mb.report_valid = 1'b1; mb.x_disp = 8'h01; mb.y_disp = 8'hFF; mb.button_status = 3'b000;
    @(negedge clk);
    check_eq("b2b_cx1", 32'(mb.cursor_x), 321);
    mb.x_disp = 8'h02; mb.y_disp = 8'hFE;
    @(negedge clk);
    mb.report_valid = 1'b0; mb.x_disp = '0; mb.y_disp = '0;
    check_eq("b2b_cx2", 32'(mb.cursor_x), 323);
    check_eq("b2b_cy2", 32'(mb.cursor_y), 237);
    repeat (2) @(negedge clk);
    check_eq("b2b_hold", 32'(mb.cursor_x), 323);

    check_eq("move_count", 32'(n_moves), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
